divider_sequencer: RTL and testbench
====================================

# divider_sequencer

Multi-cycle unsigned integer divider for the ALU. It owns one `subtractor #(N+1)` instance and drives it for N cycles using restoring division, one quotient bit per cycle. A start/busy/done handshake lets the ALU top-level issue a divide and collect the quotient, remainder and a 4-bit flag vector in the standard ALU flag layout.

## Interface
- `N`, default 8: operand, quotient and remainder width in bits; N ≥ 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a divide; sampled only in IDLE.
- `dividend`  in  N  unsigned dividend; sampled on the accepting edge.
- `divisor`  in  N  unsigned divisor; sampled on the accepting edge.
- `busy`  out  1  high while state = ITER.
- `done`  out  1  one-cycle pulse; results valid from this cycle onward.
- `quotient`  out  N  registered result; holds its value until the next accepted start.
- `remainder`  out  N  registered result; holds its value until the next accepted start.
- `flags`  out  4  bit 3 = Negative, bit 2 = Zero, bit 1 = Carry, bit 0 = Overflow. Registered together with the results.

## Operation
- States: IDLE, ITER, DONE.
- IDLE with `start`=1:
  - Latch the divisor into D (N bits).
  - Latch the dividend into shift register Q (N bits).
  - Clear partial remainder R (N+1 bits) to 0.
  - Set iteration counter to N-1.
  - Go to ITER if divisor ≠ 0, else go to DONE with the divide-by-zero result.
- IDLE with `start`=0: stay in IDLE; outputs hold.
- ITER, one iteration per edge:
  - Subtractor input a = {R[N-1:0], Q[N-1]}.
  - Subtractor input b = {1'b0, D}.
  - If the subtractor's Negative flag (b > a) is 1: R ← a, shift 0 into Q LSB.
  - Otherwise: R ← subtractor difference, shift 1 into Q LSB.
  - Q shifts left by one each iteration.
  - Counter decrements. The iteration taken with counter = 0 is the last; it moves the state to DONE.
- Entry to DONE (same edge as the last iteration, or the accepting edge for divide-by-zero):
  - `quotient` ← final Q.
  - `remainder` ← R[N-1:0].
  - `flags` updated as defined below.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored in ITER and DONE. A request must be held or reasserted in IDLE to be accepted.
- Divide-by-zero result: `quotient` = all ones, `remainder` = dividend, `flags` = 4'b0001.
- Normal-result flags:
  - [3] = 0 (unsigned).
  - [2] = 1 iff quotient == 0.
  - [1] = 0.
  - [0] = 0.
- R[N] is always 0 after an iteration. The subtractor's own Carry and Overflow outputs are unused.
- Reset (any state, including mid-ITER): state ← IDLE; counter ← 0; `busy`=0, `done`=0; `quotient`, `remainder`, `flags` = 0. An in-flight divide is discarded, with no done pulse.

## Timing
- Label the accepting edge as edge 0.
- Normal divide:
  - Iterations occur on edges 1..N.
  - `busy`=1 during the cycles between edge 0 and edge N.
  - `done`=1 in the cycle after edge N.
  - State is back in IDLE after edge N+1.
- Divide-by-zero: `done`=1 in the cycle after edge 0; `busy` never asserts.
- Earliest next accept is edge N+2 (normal) or edge 2 (divide-by-zero).
- Issue rate: one divide per N+2 cycles.
- `busy` and `done` are decoded from registered state. They are never both 1.
- `quotient`, `remainder` and `flags` change only on a DONE-entry edge or on reset. They are stable between results, including during ITER of the next divide.
- Operand changes after edge 0 do not affect the operation in flight.

## Test plan
- N=8, dividend 100, divisor 7, `start` pulsed at edge 0: `busy` high for 8 cycles, `done` after edge 8, quotient 14, remainder 2, flags 4'b0000.
- N=8, 255 ÷ 1 → quotient 255, remainder 0, flags 4'b0000. Also 255 ÷ 255 → quotient 1, remainder 0.
- N=8, 5 ÷ 9 → quotient 0, remainder 5, flags 4'b0100, `done` after edge 8.
- N=8, 42 ÷ 0 → `done` in the cycle after edge 0, `busy` never 1, quotient 255, remainder 42, flags 4'b0001.
- Start 200 ÷ 3 (expect 66 r 2). Pulse `start` with 9 ÷ 2 at edges 3 and N+1: both ignored, result stays 66 r 2. Then 9 ÷ 2 accepted in IDLE → 4 r 1.
- Assert `rst` at edge 4 of a 77 ÷ 5 divide: next cycle state IDLE, all outputs 0, no `done` pulse. A following 77 ÷ 5 → 15 r 2.

Source files
------------

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - multi-cycle restoring unsigned divider with start/busy/done handshake
//
// subtractor: unsigned a - b, flags {negative(b > a), zero, carry(no borrow), overflow(signed)}
// divider_sequencer ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 request a divide (sampled in IDLE only)
//   i_dividend, i_divisor   N-bit unsigned operands, sampled on the accepting edge
//   o_busy                  high while iterating
//   o_done                  one-cycle pulse when results become valid
//   o_quotient, o_remainder registered N-bit results
//   o_flags                 {negative, zero, carry, overflow}

module subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic [3:0]   o_flags
);
  logic [W:0] w_ext;

  // One extra bit captures the borrow, which for unsigned operands means b > a.
  assign w_ext  = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff = w_ext[W-1:0];

  assign o_flags[3] = w_ext[W];
  assign o_flags[2] = (w_ext[W-1:0] == '0);
  assign o_flags[1] = ~w_ext[W];
  assign o_flags[0] = (i_a[W-1] ^ i_b[W-1]) & (i_a[W-1] ^ w_ext[W-1]);
endmodule

module divider_sequencer #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic [3:0]   o_flags
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0]  r_d;
  logic [N-1:0]  r_q;
  logic [N:0]    r_r;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic [3:0]    r_flags;

  logic [N:0]    w_sub_a;
  logic [N:0]    w_sub_b;
  logic [N:0]    w_sub_diff;
  logic [3:0]    w_sub_flags;
  logic          w_neg;
  logic [N:0]    w_r_next;
  logic [N-1:0]  w_q_next;
  logic          w_unused;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign w_sub_a = {r_r[N-1:0], r_q[N-1]};
  assign w_sub_b = {1'b0, r_d};

  subtractor #(.W(N + 1)) u_sub (
    .i_a     (w_sub_a),
    .i_b     (w_sub_b),
    .o_diff  (w_sub_diff),
    .o_flags (w_sub_flags)
  );

  // Restore on a negative trial result, otherwise keep the difference.
  assign w_neg    = w_sub_flags[3];
  assign w_r_next = w_neg ? w_sub_a : w_sub_diff;
  assign w_q_next = {r_q[N-2:0], ~w_neg};

  // R[N] never carries information after an iteration; only negative is consumed.
  assign w_unused = ^{w_sub_flags[2:0], r_r[N]};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_divisor == '0) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_ITER:  o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_d   <= i_divisor;
            r_q   <= i_dividend;
            r_r   <= '0;
            r_cnt <= CW'(N - 1);
            if (i_divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= i_dividend;
              r_flags     <= 4'b0001;
            end
          end
        end
        S_ITER: begin
          r_r <= w_r_next;
          r_q <= w_q_next;
          if (r_cnt == '0) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[N-1:0];
            r_flags     <= {1'b0, (w_q_next == '0), 2'b00};
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_flags     = r_flags;
endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - self-checking bench for divider_sequencer
module tb_divider_sequencer;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic [3:0]   flags;

  int tests;
  int fails;

  divider_sequencer #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [3:0]   f;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one divide starting at the next edge and check timing, results and hold.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic [3:0] ef, input string name);
    int lat;
    int busy_cnt;
    logic both;
    logic held;
    logic [N-1:0] pq;
    logic [N-1:0] pr;
    logic [3:0]   pf;
    pq = quotient;
    pr = remainder;
    pf = flags;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat      = 1;
    busy_cnt = 0;
    both     = 1'b0;
    held     = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (quotient !== pq || remainder !== pr || flags !== pf) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " done_latency"}, lat, (b == 0) ? 1 : N + 1);
    check({name, " busy_cycles"}, busy_cnt, (b == 0) ? 0 : N);
    check({name, " busy_done_excl"}, {31'b0, both}, 0);
    check({name, " results_held_in_flight"}, {31'b0, held}, 1);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " flags"}, flags, ef);
    @(negedge clk);
    check({name, " done_pulse_width"}, {31'b0, done}, 0);
    check({name, " quotient_hold"}, quotient, eq);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] mq;
    logic [N-1:0] mr;
    logic [3:0]   mf;
    logic         seen_done;
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  f: 4'b0000};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  f: 4'b0000};
    vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  f: 4'b0000};
    vecs[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  f: 4'b0100};
    vecs[4] = '{a: 8'd42,  b: 8'd0,   q: 8'd255, r: 8'd42, f: 4'b0001};
    vecs[5] = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,  f: 4'b0001};
    vecs[6] = '{a: 8'd0,   b: 8'd13,  q: 8'd0,   r: 8'd0,  f: 4'b0100};
    vecs[7] = '{a: 8'd254, b: 8'd128, q: 8'd1,   r: 8'd126, f: 4'b0000};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset flags", flags, 0);

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].f, $sformatf("vec%0d", i));
    end

    // Start requests while ITER and DONE must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      start    = (k == 3 || k == N + 1);
      dividend = 8'd9;
      divisor  = 8'd2;
      if (k == N + 1) check("ignore done_at_N", {31'b0, done}, 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore busy_after", {31'b0, busy}, 0);
    check("ignore done_after", {31'b0, done}, 0);
    check("ignore quotient", quotient, 66);
    check("ignore remainder", remainder, 2);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 4'b0000, "after_ignore");

    // Reset mid-iteration discards the divide.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {31'b0, busy}, 0);
    check("midrst done", {31'b0, done}, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst flags", flags, 0);
    seen_done = 1'b0;
    repeat (12) begin
      if (done || busy) seen_done = 1'b1;
      @(negedge clk);
    end
    check("midrst no_activity", {31'b0, seen_done}, 0);
    run_div(8'd77, 8'd5, 8'd15, 8'd2, 4'b0000, "after_rst");

    // Random divides against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = (i % 8 == 0) ? 8'd0 : ((i % 2 == 0) ? N'($urandom_range(1, 15)) : N'($urandom));
      if (rb == 0) begin
        mq = '1; mr = ra; mf = 4'b0001;
      end else begin
        mq = ra / rb; mr = ra % rb; mf = {1'b0, (mq == 0), 2'b00};
      end
      run_div(ra, rb, mq, mr, mf, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
